aes_inv_mixcolumns: RTL and testbench
=====================================

# aes_inv_mixcolumns

Multi-cycle AES InvMixColumns unit for the decryption datapath. It is the inverse of the encrypt-side MixColumns stage and uses the same 4×32-bit column interface, so the round controller drives both the same way. The block captures a 128-bit state on a start edge and serially multiply-accumulates each output byte over GF(2^8) with the matrix {0e,0b,0d,09} (rows rotated right per row). It then asserts `done` with the result held on the outputs.

## Interface
Parameters: none.

Ports:
- `clk` input 1: rising-edge clock; the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `start_in` input 1: level request; the rising edge is detected internally.
- `state0` input 32: column 0; [7:0]=row0, [15:8]=row1, [23:16]=row2, [31:24]=row3.
- `state1`, `state2`, `state3` input 32 each: columns 1–3, same byte order as `state0`.
- `state_out0`..`state_out3` output 32 each: result columns, same byte order; registered.
- `done` output 1: result valid; registered.

## Operation
- Edge detect: register `start_q <= start_in`. `start = start_in & ~start_q`. `start_q` resets to 0.
- FSM states:
  - IDLE: entered on reset. `start` -> LOAD.
  - LOAD: one cycle, entered at the `start` edge. Captures the 16 input bytes into `in_reg`, clears the 16 accumulators `acc`, clears `cnt`, clears `done`. Next state RUN.
  - RUN: one MAC per cycle. j=`cnt[5:2]` (output byte), k=`cnt[1:0]` (term), c=j/4, r=j%4. Update: `acc[j] <= acc[j] ^ gmul(M[r][k], in_reg[4c+k])`. M row r = rotate-right by r of {0e,0b,0d,09}. `cnt` increments; at `cnt`=63 -> DONE.
  - DONE: `done`=1. Outputs hold until the next `start` -> LOAD.
- gmul: xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 0). Use x2, x4=xtime(x2), x8=xtime(x4).
  - 09 = x8^a
  - 0b = x8^x2^a
  - 0d = x8^x4^a
  - 0e = x8^x4^x2
- All arithmetic is 8-bit XOR. There are no carries.
- `start` during LOAD or RUN is ignored; the in-progress operation completes. A new edge is required after that. `start` in DONE restarts the operation.
- `state_outN` drive `acc` directly. They are defined only while `done`=1; during RUN they show partial sums.
- Input ports are sampled only in LOAD. Changes at other times have no effect.

## Timing
- Reset (async assert, any state): FSM=IDLE, `cnt`=0, all `in_reg`/`acc`=0, `state_out0..3`=32'h0, `done`=0. Deassertion is synchronized by the integrator.
- Reset mid-RUN aborts the operation. Outputs go to 0 immediately and `done` is 0.
- Edge E0: `start_in` sampled 1 while `start_q`=0. Inputs are captured at E0 and `done` falls after E0.
- MACs occur at edges E1..E64. `done`=1 and the outputs are final after E64: latency 64 cycles from the capture edge.
- `start_in` held high: one operation only. It must drop for at least one cycle to re-arm.
- Back-to-back: a new rising edge in DONE at edge En gives `done`=0 after En, results after En+64.

## Configuration
- `AES_INV_MIXCOL_PARALLEL_EN` defined: RUN computes one full output byte per cycle, with all 4 products XORed combinationally. `cnt` becomes 4 bits and RUN lasts 16 cycles, so `done`=1 after E16. Results are bit-identical.
- Not defined (default): one product per cycle, 64-cycle latency, single gmul instance.

## Test plan
- Reset: hold `reset`=0 with random inputs -> all outputs 0 and `done`=0. Assert reset mid-RUN at E30 -> outputs 0 and `done` 0 immediately.
- FIPS-197 columns:
  - Stimulus: `state0`=32'hbca14d8e, `state1`=32'h9d58dc9f, `state2`=32'h01010101, `state3`=32'hc6c6c6c6.
  - Response: `done`=1 exactly after E64; `state_out0`=32'h455313db, `state_out1`=32'h5c220af2, `state_out2`=32'h01010101, `state_out3`=32'hc6c6c6c6.
- Second vector: `state0`=32'hd6d7d5d5, `state1`=32'hf8bd7e4d, other columns 0 -> `state_out0`=32'hd5d4d4d4, `state_out1`=32'h4c31262d, `state_out2`=`state_out3`=0.
- Round trip: 100 random states passed through encrypt-side MixColumns then this block -> output equals the original state each time.
- Handshake: pulse `start_in` again at E20 -> ignored, results after E64 unchanged. Hold `start_in` high 200 cycles -> one operation only. Drop and re-raise `start_in` in DONE -> `done` falls next cycle and new results appear after 64 more cycles.
- With `AES_INV_MIXCOL_PARALLEL_EN`: rerun the FIPS-197 column and second-vector scenarios -> same outputs, `done` after E16.

Source files
------------

// File: rtl/aes_inv_mixcolumns.sv
// Multi-cycle AES InvMixColumns: serial GF(2^8) multiply-accumulate over a captured 128-bit state.
// Define AES_INV_MIXCOL_PARALLEL_EN to compute one full output byte per cycle (16-cycle latency).
module aes_inv_mixcolumns (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

`ifdef AES_INV_MIXCOL_PARALLEL_EN
  localparam int unsigned CNT_W = 4;
`else
  localparam int unsigned CNT_W = 6;
`endif

  state_t             state;
  logic               start_q;
  logic               start;
  logic [CNT_W-1:0]   cnt;
  logic [15:0][7:0]   in_reg;
  logic [15:0][7:0]   acc;
  logic [3:0]         byte_idx;
  logic [7:0]         mac_val;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // sel is the column offset within the base row {0e,0b,0d,09}
  function automatic logic [7:0] gmul(input logic [1:0] sel, input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      2'd0:    return x8 ^ x4 ^ x2;
      2'd1:    return x8 ^ x2 ^ a;
      2'd2:    return x8 ^ x4 ^ a;
      default: return x8 ^ a;
    endcase
  endfunction

  assign start = start_in & ~start_q;

`ifdef AES_INV_MIXCOL_PARALLEL_EN
  always_comb begin
    byte_idx = cnt;
    mac_val  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      mac_val = mac_val ^ gmul(2'(2'(k) - byte_idx[1:0]),
                               in_reg[{byte_idx[3:2], 2'(k)}]);
    end
  end
`else
  logic [1:0] term;

  always_comb begin
    byte_idx = cnt[5:2];
    term     = cnt[1:0];
    mac_val  = gmul(2'(term - byte_idx[1:0]), in_reg[{byte_idx[3:2], term}]);
  end
`endif

  // Capture happens on the edge that enters LOAD, so LOAD already performs
  // the first MAC and the last one lands exactly on E64 (E16 in parallel).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      cnt     <= '0;
      in_reg  <= '0;
      acc     <= '0;
      done    <= 1'b0;
    end else begin
      start_q <= start_in;
      if (start && (state == S_IDLE || state == S_DONE)) begin
        in_reg <= {state3, state2, state1, state0};
        acc    <= '0;
        cnt    <= '0;
        done   <= 1'b0;
        state  <= S_LOAD;
      end else begin
        case (state)
          S_LOAD, S_RUN: begin
            acc[byte_idx] <= acc[byte_idx] ^ mac_val;
            cnt           <= cnt + 1'b1;
            if (cnt == '1) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign state_out0 = acc[3:0];
  assign state_out1 = acc[7:4];
  assign state_out2 = acc[11:8];
  assign state_out3 = acc[15:12];

endmodule

// File: tb/tb_aes_inv_mixcolumns.sv
// Scoreboard bench for aes_inv_mixcolumns; expected results come from a textbook GF(2^8) model.
module tb_aes_inv_mixcolumns;

`ifdef AES_INV_MIXCOL_PARALLEL_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 64;
`endif
  localparam int PULSE_EDGE = (LAT == 64) ? 20 : 5;
  localparam int RST_EDGE   = (LAT == 64) ? 30 : 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [31:0] state0, state1, state2, state3;
  logic [31:0] state_out0, state_out1, state_out2, state_out3;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_q[$];

  aes_inv_mixcolumns dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .state0     (state0),
    .state1     (state1),
    .state2     (state2),
    .state3     (state3),
    .state_out0 (state_out0),
    .state_out1 (state_out1),
    .state_out2 (state_out2),
    .state_out3 (state_out3),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gf_mul(a0,8'h0e)^gf_mul(a1,8'h0b)^gf_mul(a2,8'h0d)^gf_mul(a3,8'h09);
      o[32*c+8  +: 8] = gf_mul(a0,8'h09)^gf_mul(a1,8'h0e)^gf_mul(a2,8'h0b)^gf_mul(a3,8'h0d);
      o[32*c+16 +: 8] = gf_mul(a0,8'h0d)^gf_mul(a1,8'h09)^gf_mul(a2,8'h0e)^gf_mul(a3,8'h0b);
      o[32*c+24 +: 8] = gf_mul(a0,8'h0b)^gf_mul(a1,8'h0d)^gf_mul(a2,8'h09)^gf_mul(a3,8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gf_mul(a0,8'h02)^gf_mul(a1,8'h03)^a2^a3;
      o[32*c+8  +: 8] = a0^gf_mul(a1,8'h02)^gf_mul(a2,8'h03)^a3;
      o[32*c+16 +: 8] = a0^a1^gf_mul(a2,8'h02)^gf_mul(a3,8'h03);
      o[32*c+24 +: 8] = gf_mul(a0,8'h03)^a1^a2^gf_mul(a3,8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [127:0] outs();
    return {state_out3, state_out2, state_out1, state_out0};
  endfunction

  task automatic scramble();
    {state3, state2, state1, state0} = rand128();
  endtask

  // One-cycle start pulse; returns at the negedge after the capture edge E0.
  task automatic launch(input logic [127:0] vec, output logic done_e0);
    @(negedge clk);
    {state3, state2, state1, state0} = vec;
    start_in = 1'b1;
    exp_q.push_back(inv_mix(vec));
    @(negedge clk);
    start_in = 1'b0;
    done_e0  = done;
  endtask

  // Counts edges since E0 until done, with a bounded budget; inputs churn meanwhile.
  task automatic wait_done(output int lat, output logic ok);
    int n = 1;
    while (done !== 1'b1 && n < LAT + 20) begin
      scramble();
      @(negedge clk);
      n++;
    end
    lat = n - 1;
    ok  = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      scramble();
      start_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    checks++;
    if (outs() !== 128'h0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", outs());
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b expected 0", done);
    end
    start_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fips();
    logic d0, ok; int lat; logic [127:0] exp;
    launch({32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e}, d0);
    wait_done(lat, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || lat != LAT) begin
      errors++; $display("FAIL fips_latency: got %0d (done=%b) expected %0d", lat, done, LAT);
    end
    checks++;
    if (outs() !== exp) begin
      errors++; $display("FAIL fips_model: got %h expected %h", outs(), exp);
    end
    checks++;
    if (outs() !== {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db}) begin
      errors++; $display("FAIL fips_vector: got %h expected c6c6c6c6010101015c220af2455313db", outs());
    end
    repeat (5) begin scramble(); @(negedge clk); end
    checks++;
    if (done !== 1'b1 || outs() !== exp) begin
      errors++; $display("FAIL fips_hold: got done=%b %h expected done=1 %h", done, outs(), exp);
    end
  endtask

  task automatic test_second_vector();
    logic d0, ok; int lat; logic [127:0] exp;
    launch({32'h0, 32'h0, 32'hf8bd7e4d, 32'hd6d7d5d5}, d0);
    wait_done(lat, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || lat != LAT) begin
      errors++; $display("FAIL vec2_latency: got %0d (done=%b) expected %0d", lat, done, LAT);
    end
    checks++;
    if (outs() !== {32'h0, 32'h0, 32'h4c31262d, 32'hd5d4d4d4} || outs() !== exp) begin
      errors++; $display("FAIL vec2_out: got %h expected 00000000000000004c31262dd5d4d4d4", outs());
    end
  endtask

  task automatic test_round_trip();
    logic d0, ok; int lat; logic [127:0] orig, exp;
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      orig = rand128();
      launch(fwd_mix(orig), d0);
      wait_done(lat, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || outs() !== orig || outs() !== exp) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL round_trip[%0d]: got %h expected %h", i, outs(), orig);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic d0; logic [127:0] exp; int n;
    launch(rand128(), d0);
    n = 1;
    while (done !== 1'b1 && n < LAT + 20) begin
      scramble();
      start_in = (n == PULSE_EDGE);
      @(negedge clk);
      n++;
    end
    start_in = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || n - 1 != LAT || outs() !== exp) begin
      errors++; $display("FAIL start_ignored: got lat=%0d done=%b %h expected lat=%0d %h", n - 1, done, outs(), LAT, exp);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || outs() !== exp) begin
      errors++; $display("FAIL start_ignored_hold: got done=%b %h expected done=1 %h", done, outs(), exp);
    end
  endtask

  task automatic test_hold_high();
    logic [127:0] exp; logic prev; int rises = 0;
    @(negedge clk);
    {state3, state2, state1, state0} = rand128();
    exp_q.push_back(inv_mix({state3, state2, state1, state0}));
    start_in = 1'b1;
    prev = done;
    repeat (200) begin
      @(negedge clk);
      scramble();
      if (!prev && done) rises++;
      prev = done;
    end
    exp = exp_q.pop_front();
    checks++;
    if (rises != 1) begin
      errors++; $display("FAIL hold_high_ops: got %0d completions expected 1", rises);
    end
    checks++;
    if (done !== 1'b1 || outs() !== exp) begin
      errors++; $display("FAIL hold_high_out: got done=%b %h expected done=1 %h", done, outs(), exp);
    end
    start_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic d0, ok; int lat; logic [127:0] exp;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_pre_done: got %b expected 1", done);
    end
    launch(rand128(), d0);
    checks++;
    if (d0 !== 1'b0) begin
      errors++; $display("FAIL b2b_done_fall: got %b expected 0", d0);
    end
    wait_done(lat, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || lat != LAT || outs() !== exp) begin
      errors++; $display("FAIL b2b_result: got lat=%0d %h expected lat=%0d %h", lat, outs(), LAT, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    logic d0; logic [127:0] junk; int stray = 0;
    launch(rand128(), d0);
    repeat (RST_EDGE) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 128'h0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: got done=%b %h expected done=0 0", done, outs());
    end
    junk = exp_q.pop_back();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL reset_abort: got done high %0d cycles expected 0", stray);
    end
  endtask

  initial begin
    reset = 1'b0;
    start_in = 1'b0;
    {state3, state2, state1, state0} = '0;
    test_reset();
    test_fips();
    test_second_vector();
    test_round_trip();
    test_start_ignored();
    test_hold_high();
    test_back_to_back();
    test_reset_mid_run();
    test_fips();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
